// File: rtl/seq_scan_sched.sv
// seq_scan_sched: round-robin time-sharing of one serial pattern detector across N_REQ bit sources.
// Optional stall timeout enabled by defining SEQ_SCAN_TIMEOUT_EN.
module seq_scan_sched #(
   parameter int N_REQ     = 4,
   parameter int FRAME_LEN = 16,
   parameter int CNT_W     = 8,
   parameter int TIMEOUT   = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] req_i,
   input  logic [N_REQ-1:0] bit_valid_i,
   input  logic [N_REQ-1:0] bit_data_i,
   output logic [N_REQ-1:0] bit_ready_o,
   output logic [N_REQ-1:0] gnt_o,
   output logic             det_clear_o,
   output logic             det_step_o,
   output logic             det_bit_o,
   input  logic             det_z_i,
   output logic             done_o,
   output logic [2:0]       done_id_o,
   output logic [CNT_W-1:0] done_count_o,
   output logic             done_abort_o
);
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] CLEAR  = 3'd1;
   localparam logic [2:0] STREAM = 3'd2;
   localparam logic [2:0] SAMPLE = 3'd3;
   localparam logic [2:0] REPORT = 3'd4;

   if (N_REQ < 2 || N_REQ > 8 || FRAME_LEN < 1 || FRAME_LEN > 255 || TIMEOUT < 1) begin : g_bad_cfg
      $error("seq_scan_sched: parameter out of range");
   end

   logic [2:0]       state_q, state_d, idx_q, idx_d, last_q, last_d, pick;
   logic [7:0]       bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0] match_q, match_d, done_count_q, done_count_d;
   logic [N_REQ-1:0] gnt_q, gnt_d, bit_ready_q, bit_ready_d;
   logic             abort_q, abort_d, det_clear_q, det_clear_d, det_step_q, det_step_d;
   logic             det_bit_q, det_bit_d, done_q, done_d, done_abort_q, done_abort_d;
   logic [2:0]       done_id_q, done_id_d;
   logic             req_on, valid_on, data_on;
   int               best, gap;
`ifdef SEQ_SCAN_TIMEOUT_EN
   localparam int SW = $clog2(TIMEOUT + 1);
   logic [SW-1:0] stall_q, stall_d;
`endif

   // Rotating priority: distance of each requester from the one after the last winner
   always_comb begin
      pick = '0;
      best = N_REQ;
      gap  = 0;
      for (int i = 0; i < N_REQ; i++) begin
         gap = (i + N_REQ - 1 - int'(last_q)) % N_REQ;
         if (req_i[i] && gap < best) begin
            best = gap;
            pick = 3'(i);
         end
      end
   end

   assign req_on   = |(req_i & gnt_q);
   assign valid_on = |(bit_valid_i & gnt_q);
   assign data_on  = |(bit_data_i & gnt_q);

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      last_d       = last_q;
      bit_cnt_d    = bit_cnt_q;
      match_d      = match_q;
      abort_d      = abort_q;
      gnt_d        = gnt_q;
      det_step_d   = 1'b0;
      det_bit_d    = 1'b0;
      done_d       = 1'b0;
      done_id_d    = done_id_q;
      done_count_d = done_count_q;
      done_abort_d = done_abort_q;
`ifdef SEQ_SCAN_TIMEOUT_EN
      stall_d      = stall_q;
`endif
      case (state_q)
         IDLE: if (|req_i) begin
            state_d   = CLEAR;
            idx_d     = pick;
            gnt_d     = N_REQ'(1) << pick;
            bit_cnt_d = '0;
            match_d   = '0;
            abort_d   = 1'b0;
`ifdef SEQ_SCAN_TIMEOUT_EN
            stall_d   = '0;
`endif
         end
         CLEAR: begin
            state_d = req_on ? STREAM : REPORT;
            abort_d = !req_on;
         end
         STREAM: if (!req_on) begin
            state_d = REPORT;
            abort_d = 1'b1;
         end else if (valid_on) begin
            state_d    = SAMPLE;
            det_step_d = 1'b1;
            det_bit_d  = data_on;
            bit_cnt_d  = bit_cnt_q + 1'b1;
`ifdef SEQ_SCAN_TIMEOUT_EN
            stall_d    = '0;
         end else if (stall_q == SW'(TIMEOUT - 1)) begin
            state_d = REPORT;
            abort_d = 1'b1;
         end else begin
            stall_d = stall_q + 1'b1;
`endif
         end
         SAMPLE: begin
            match_d = (det_z_i && match_q != '1) ? match_q + 1'b1 : match_q;
            state_d = (!req_on || bit_cnt_q == 8'(FRAME_LEN)) ? REPORT : STREAM;
            abort_d = !req_on;
         end
         REPORT: begin
            state_d      = IDLE;
            done_d       = 1'b1;
            done_id_d    = idx_q;
            done_count_d = match_q;
            done_abort_d = abort_q;
            last_d       = idx_q;
            gnt_d        = '0;
         end
         default: state_d = IDLE;
      endcase
      det_clear_d = state_d == CLEAR;
      bit_ready_d = state_d == STREAM ? gnt_d : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         last_q       <= 3'(N_REQ - 1);
         bit_cnt_q    <= '0;
         match_q      <= '0;
         abort_q      <= 1'b0;
         gnt_q        <= '0;
         bit_ready_q  <= '0;
         det_clear_q  <= 1'b0;
         det_step_q   <= 1'b0;
         det_bit_q    <= 1'b0;
         done_q       <= 1'b0;
         done_id_q    <= '0;
         done_count_q <= '0;
         done_abort_q <= 1'b0;
`ifdef SEQ_SCAN_TIMEOUT_EN
         stall_q      <= '0;
`endif
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         last_q       <= last_d;
         bit_cnt_q    <= bit_cnt_d;
         match_q      <= match_d;
         abort_q      <= abort_d;
         gnt_q        <= gnt_d;
         bit_ready_q  <= bit_ready_d;
         det_clear_q  <= det_clear_d;
         det_step_q   <= det_step_d;
         det_bit_q    <= det_bit_d;
         done_q       <= done_d;
         done_id_q    <= done_id_d;
         done_count_q <= done_count_d;
         done_abort_q <= done_abort_d;
`ifdef SEQ_SCAN_TIMEOUT_EN
         stall_q      <= stall_d;
`endif
      end
   end

   assign gnt_o        = gnt_q;
   assign bit_ready_o  = bit_ready_q;
   assign det_clear_o  = det_clear_q;
   assign det_step_o   = det_step_q;
   assign det_bit_o    = det_bit_q;
   assign done_o       = done_q;
   assign done_id_o    = done_id_q;
   assign done_count_o = done_count_q;
   assign done_abort_o = done_abort_q;
endmodule

// File: tb/tb_seq_scan_sched.sv
// tb_seq_scan_sched: directed bench for seq_scan_sched with a 1101 Mealy detector model.
module tb_seq_scan_sched;
   logic       clk = 1'b0, reset = 1'b1;
   logic [3:0] req = '0, bit_valid = '0, bit_data, bit_ready, gnt;
   logic       det_clear, det_step, det_bit, det_z, done, done_abort, mealy;
   logic [2:0] done_id;
   logic [1:0] done_count;
   logic [3:0] fb = 4'b1011;
   logic [3:0] sh = '0;
   int         nstep = 0, overlap = 0, mode = 0;
   int         checks = 0, failures = 0;

   seq_scan_sched #(.N_REQ(4), .FRAME_LEN(4), .CNT_W(2)) dut (
      .clk(clk), .reset(reset), .req_i(req), .bit_valid_i(bit_valid), .bit_data_i(bit_data),
      .bit_ready_o(bit_ready), .gnt_o(gnt), .det_clear_o(det_clear), .det_step_o(det_step),
      .det_bit_o(det_bit), .det_z_i(det_z), .done_o(done), .done_id_o(done_id),
      .done_count_o(done_count), .done_abort_o(done_abort)
   );

   always #5 clk = ~clk;

   // Detector model: shifts on det_step, cleared by det_clear; z is Mealy on the stepped bit
   always @(posedge clk) begin
      if (det_clear) begin
         nstep <= 0;
         sh    <= '0;
      end else if (det_step) begin
         nstep <= nstep + 1;
         sh    <= {sh[2:0], det_bit};
      end
      if (det_clear && det_step) overlap <= overlap + 1;
   end
   assign mealy    = det_step && {sh[2:0], det_bit} == 4'b1101;
   assign det_z    = (mode == 1) || (mode == 2 && !det_step) || mealy;
   assign bit_data = {4{fb[nstep % 4]}};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_gnt(input int limit);
      for (int i = 0; i < limit && gnt == '0; i++) tick();
   endtask

   task automatic wait_done(input int limit, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!done && n < limit);
      if (!done) n = -1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if ({gnt, bit_ready, det_clear, det_step, det_bit, done, done_id, done_count, done_abort} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got gnt=%b rdy=%b clr=%b stp=%b bit=%b done=%b id=%0d cnt=%0d ab=%b, required all zero",
                  gnt, bit_ready, det_clear, det_step, det_bit, done, done_id, done_count, done_abort);
      end
      reset = 1'b0;
   endtask

   task automatic test_single_frame();
      int n;
      mode = 0; bit_valid = 4'hF; req = 4'b0001;
      tick();
      checks++;
      if (gnt !== 4'b0001 || det_clear !== 1'b1) begin
         failures++;
         $display("FAIL grant_latency: got gnt=%b clr=%b, required gnt=0001 clr=1", gnt, det_clear);
      end
      tick();
      checks++;
      if (bit_ready !== 4'b0001 || det_clear !== 1'b0) begin
         failures++;
         $display("FAIL stream_ready: got rdy=%b clr=%b, required rdy=0001 clr=0", bit_ready, det_clear);
      end
      wait_done(40, n);
      req = '0;
      checks++;
      if (n !== 9) begin
         failures++;
         $display("FAIL frame_latency: got %0d cycles after gnt, required 10", n + 1);
      end
      checks++;
      if (done_id !== 3'd0 || done_count !== 2'd1 || done_abort !== 1'b0 || gnt !== 4'b0000) begin
         failures++;
         $display("FAIL single_result: got id=%0d cnt=%0d ab=%b gnt=%b, required id=0 cnt=1 ab=0 gnt=0000",
                  done_id, done_count, done_abort, gnt);
      end
      tick();
      checks++;
      if (done !== 1'b0 || done_count !== 2'd1 || done_id !== 3'd0) begin
         failures++;
         $display("FAIL done_hold: got done=%b cnt=%0d id=%0d, required done=0 cnt=1 id=0", done, done_count, done_id);
      end
   endtask

   task automatic test_round_robin();
      int n;
      logic [3:0] g;
      reset = 1'b1;
      tick();
      reset = 1'b0; mode = 0; bit_valid = 4'hF; req = 4'hF;
      for (int f = 0; f < 5; f++) begin
         wait_gnt(10);
         g = gnt;
         wait_done(40, n);
         if (f == 4) req = '0;
         checks++;
         if (g !== 4'b0001 << (f % 4)) begin
            failures++;
            $display("FAIL rr_grant%0d: got %b, required %b", f, g, 4'b0001 << (f % 4));
         end
         checks++;
         if (done !== 1'b1 || done_id !== 3'(f % 4) || done_count !== 2'd1) begin
            failures++;
            $display("FAIL rr_done%0d: got done=%b id=%0d cnt=%0d, required done=1 id=%0d cnt=1", f, done, done_id, done_count, f % 4);
         end
      end
      tick();
   endtask

   task automatic test_saturate();
      int n;
      mode = 1; req = 4'b0001;
      wait_gnt(10);
      wait_done(40, n);
      req = '0;
      checks++;
      if (done !== 1'b1 || done_count !== 2'd3 || done_abort !== 1'b0) begin
         failures++;
         $display("FAIL saturate: got done=%b cnt=%0d ab=%b, required done=1 cnt=3 ab=0", done, done_count, done_abort);
      end
      mode = 0;
      tick();
   endtask

   task automatic test_stray_z();
      int n;
      mode = 2; req = 4'b0100;
      wait_gnt(10);
      wait_done(40, n);
      req = '0;
      checks++;
      if (done !== 1'b1 || done_count !== 2'd1 || done_id !== 3'd2) begin
         failures++;
         $display("FAIL stray_z_ignored: got done=%b cnt=%0d id=%0d, required done=1 cnt=1 id=2", done, done_count, done_id);
      end
      mode = 0;
      tick();
   endtask

   task automatic test_abort();
      int n, ns;
      mode = 1; req = 4'b0010; ns = 0;
      wait_gnt(10);
      for (int i = 0; i < 20 && ns < 2; i++) begin
         tick();
         if (det_step) ns++;
      end
      req = '0;
      wait_done(20, n);
      checks++;
      if (done !== 1'b1 || done_abort !== 1'b1 || done_count !== 2'd2 || done_id !== 3'd1) begin
         failures++;
         $display("FAIL abort_result: got done=%b ab=%b cnt=%0d id=%0d, required done=1 ab=1 cnt=2 id=1", done, done_abort, done_count, done_id);
      end
      checks++;
      if (nstep !== 2 || gnt !== 4'b0000) begin
         failures++;
         $display("FAIL abort_steps: got steps=%0d gnt=%b, required steps=2 gnt=0000", nstep, gnt);
      end
      mode = 0;
      tick();
   endtask

   task automatic test_reset_mid();
      int n;
      bit_valid = 4'hF; req = 4'b0001;
      wait_gnt(10);
      tick();
      tick();
      tick();
      reset = 1'b1; req = '0;
      tick();
      checks++;
      if ({gnt, bit_ready, det_clear, det_step, det_bit, done, done_id, done_count, done_abort} !== '0) begin
         failures++;
         $display("FAIL reset_mid: got gnt=%b rdy=%b clr=%b stp=%b done=%b id=%0d cnt=%0d ab=%b, required all zero",
                  gnt, bit_ready, det_clear, det_step, done, done_id, done_count, done_abort);
      end
      reset = 1'b0; req = 4'b0100;
      wait_gnt(10);
      checks++;
      if (gnt !== 4'b0100) begin
         failures++;
         $display("FAIL reset_regrant: got %b, required 0100", gnt);
      end
      wait_done(40, n);
      req = '0;
      checks++;
      if (done !== 1'b1 || done_id !== 3'd2 || done_abort !== 1'b0) begin
         failures++;
         $display("FAIL reset_frame: got done=%b id=%0d ab=%b, required done=1 id=2 ab=0", done, done_id, done_abort);
      end
      tick();
   endtask

   task automatic test_timeout();
      int n;
      bit seen;
      bit_valid = '0; req = 4'b0001; seen = 1'b0;
      wait_gnt(10);
`ifdef SEQ_SCAN_TIMEOUT_EN
      wait_done(200, n);
      req = '0;
      checks++;
      if (n !== 66 || done_abort !== 1'b1 || done_count !== 2'd0) begin
         failures++;
         $display("FAIL timeout: got n=%0d ab=%b cnt=%0d, required n=66 ab=1 cnt=0", n, done_abort, done_count);
      end
`else
      for (int i = 0; i < 1000; i++) begin
         tick();
         seen |= done;
      end
      checks++;
      if (seen || gnt !== 4'b0001) begin
         failures++;
         $display("FAIL no_timeout: got done_seen=%b gnt=%b, required done_seen=0 gnt=0001", seen, gnt);
      end
      req = '0;
      wait_done(10, n);
      checks++;
      if (n !== 2 || done_abort !== 1'b1 || done_count !== 2'd0) begin
         failures++;
         $display("FAIL stall_abort: got n=%0d ab=%b cnt=%0d, required n=2 ab=1 cnt=0", n, done_abort, done_count);
      end
`endif
      tick();
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_round_robin();
      test_saturate();
      test_stray_z();
      test_abort();
      test_reset_mid();
      test_timeout();
      checks++;
      if (overlap !== 0) begin
         failures++;
         $display("FAIL step_clear_overlap: got %0d overlapping cycles, required 0", overlap);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/seq_scan_sched.md
# seq_scan_sched

Round-robin scheduler that time-shares one external 4-bit serial pattern detector among `N_REQ` serial bit sources. It grants one requester per frame, clears the detector, streams `FRAME_LEN` bits from that requester into it, and counts detector match pulses. It reports the per-frame match count tagged with the requester ID. It sits between the per-channel serial front ends and the shared detector instance.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `FRAME_LEN`, 16: bits per frame, 1..255.
- `CNT_W`, 8: match-count width.
- `TIMEOUT`, 64: stall limit in cycles; used only with the configuration macro.

- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `req`  in  N_REQ  per-requester frame request, level; held for the whole frame.
- `bit_valid`  in  N_REQ  per-requester bit valid.
- `bit_data`  in  N_REQ  per-requester serial bit.
- `bit_ready`  out  N_REQ  one-hot ready to the granted requester only.
- `gnt`  out  N_REQ  one-hot grant; zero when idle.
- `det_clear`  out  1  detector synchronous clear strobe.
- `det_step`  out  1  detector shift strobe.
- `det_bit`  out  1  bit presented with `det_step`.
- `det_z`  in  1  detector match output; valid the cycle after `det_step`.
- `done`  out  1  one-cycle frame-complete pulse.
- `done_id`  out  3  requester index of the reported frame.
- `done_count`  out  CNT_W  matches in the frame.
- `done_abort`  out  1  frame ended early; qualified by `done`.

## Operation
- States: IDLE, CLEAR, STREAM, SAMPLE, REPORT.
- IDLE: if `req` is nonzero, pick the first set bit searching upward from `last+1`, modulo N_REQ.
  - Set `gnt`, latch the index, clear `bit_cnt` and `match_cnt`, then go to CLEAR.
  - With no request, stay in IDLE.
- CLEAR: assert `det_clear` for exactly 1 cycle, then go to STREAM.
- STREAM: assert `bit_ready[idx]`.
  - On `bit_valid[idx]`: assert `det_step`, drive `det_bit = bit_data[idx]`, increment `bit_cnt`, and go to SAMPLE.
- SAMPLE: add `det_z` to `match_cnt`, saturating at 2^CNT_W-1.
  - If `bit_cnt == FRAME_LEN`, go to REPORT with abort=0.
  - Otherwise return to STREAM.
- REPORT: pulse `done` with the latched id, count, and abort.
  - Set `last = idx` and drop `gnt`, then go to IDLE.
- Abort: `req[idx]` low in CLEAR, STREAM, or SAMPLE.
  - The count includes any `det_z` sampled that cycle in SAMPLE.
  - Go to REPORT with abort=1; no further `det_step` is issued.
- Requests from non-granted requesters are ignored until IDLE; `bit_valid` on non-granted lanes is ignored.
- `det_step` and `det_clear` are never asserted in the same cycle.

## Timing
- Reset values:
  - Outputs: `gnt`=0, `bit_ready`=0, `det_clear`=0, `det_step`=0, `det_bit`=0, `done`=0, `done_id`=0, `done_count`=0, `done_abort`=0.
  - Internal: state=IDLE, `last`=N_REQ-1, so requester 0 wins first.
- All outputs are registered. Reset mid-frame returns to IDLE next edge with no `done`.
- Grant latency: `req` seen in IDLE → `gnt` and `det_clear` high on the next cycle.
- Throughput: 1 bit per 2 cycles maximum.
- Full frame with `bit_valid` held high: 1 (CLEAR) + 2·FRAME_LEN + 1 (REPORT) cycles from `gnt` to `done`.
- `done_*` hold their values until the next `done`.
- `det_z` is sampled only in SAMPLE; `det_z` at any other time is ignored.

## Configuration
- `SEQ_SCAN_TIMEOUT_EN` defined: a stall counter clears on every `det_step` and increments in STREAM while `bit_valid[idx]` is low.
  - Reaching TIMEOUT forces REPORT with abort=1.
- Not defined: no timeout logic; STREAM waits indefinitely.

## Test plan
- `req`=0001, FRAME_LEN=4, bits 1,1,0,1 with the detector returning `det_z`=1 after the 4th step → `done`, `done_id`=0, `done_count`=1, `done_abort`=0, 10 cycles after `gnt`.
- `req`=1111 held, 4 frames → grant order 0,1,2,3, then 0 again; no requester skipped.
- `det_z`=1 on every step, CNT_W=2, FRAME_LEN=8 → `done_count`=3 (saturated).
- `req[idx]` dropped after 2 accepted bits → `done_abort`=1, `done_count` = matches so far, no third `det_step`, `gnt`=0 after REPORT.
- `reset` asserted in STREAM → next cycle all outputs at reset values and no `done`. Then `req`=0100 → grant index 2.
- With `SEQ_SCAN_TIMEOUT_EN` and TIMEOUT=64, `bit_valid` held low in STREAM → `done_abort`=1 after 64 stall cycles. Without the macro, no `done` after 1000 cycles.
